// File: rtl/bcd_dabble_if.sv
// Handshake bundle between a binary producer and the BCD converter.
// The master drives in_* and out_ready; the slave (converter) drives the rest.
interface bcd_dabble_if #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [IN_W-1:0]       in_bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_ovf;
    logic                  busy;

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, out_bcd, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, out_bcd, out_ovf, busy
    );
endinterface

// File: rtl/bcd_dabble_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// valid/ready on both sides and a sticky overflow flag.
module bcd_dabble_conv #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    bcd_dabble_if.slave  bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   bcd_q, bcd_adj;
    logic [IN_W-1:0] sh_q;
    logic [CW-1:0]   cnt_q;
    logic            ovf_q;
    logic            accept;

    assign bus.in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == CONV);
    assign bus.out_bcd   = bcd_q;
    assign bus.out_ovf   = ovf_q;

    // Add 3 to every digit >= 5 so the following left shift carries decimally.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CONV;
            CONV:    if (cnt_q == CW'(1)) state_d = DONE;
            DONE: begin
                if (accept)             state_d = CONV;
                else if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_q <= '0;
            sh_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            bcd_q <= '0;
            sh_q  <= bus.in_bin;
            cnt_q <= CW'(IN_W);
            ovf_q <= 1'b0;
        end else if (state_q == CONV) begin
            // A carry out of the top digit means the value no longer fits.
            bcd_q <= {bcd_adj[BW-2:0], sh_q[IN_W-1]};
            ovf_q <= ovf_q | bcd_adj[BW-1];
            sh_q  <= sh_q << 1;
            cnt_q <= cnt_q - CW'(1);
        end
    end
endmodule

// File: tb/tb_bcd_dabble_conv.sv
// Bench for bcd_dabble_conv: a 3-digit and a 2-digit instance checked against
// a decimal reference computed with integer division.
module tb_bcd_dabble_conv;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    bcd_dabble_if #(.IN_W(8), .DIGITS(3)) ifa ();
    bcd_dabble_if #(.IN_W(8), .DIGITS(2)) ifb ();

    bcd_dabble_conv #(.IN_W(8), .DIGITS(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    bcd_dabble_conv #(.IN_W(8), .DIGITS(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    // {ovf, bcd} from plain decimal arithmetic
    function automatic logic [12:0] ref3(input int v);
        logic [11:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return {(v > 999), r};
    endfunction

    function automatic logic [8:0] ref2(input int v);
        logic [7:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 2; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return {(v > 99), r};
    endfunction

    // Called at a negedge; leaves the DUT holding its result in DONE.
    task automatic conv_a(input logic [7:0] v, output logic [11:0] bcd, output logic ovf, output int lat);
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.in_bin    = v;
        #1;
        tests++;
        if (ifa.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL conv_a_ready: in_ready=%b exp 1", ifa.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        ifa.in_valid = 1'b0;
        lat = 0;
        while (!ifa.out_valid && lat < 50) begin
            ifa.in_bin = 8'($urandom);
            @(negedge clk);
            lat++;
        end
        bcd = ifa.out_bcd;
        ovf = ifa.out_ovf;
    endtask

    task automatic conv_b(input logic [7:0] v, output logic [7:0] bcd, output logic ovf, output int lat);
        ifb.out_ready = 1'b0;
        ifb.in_valid  = 1'b1;
        ifb.in_bin    = v;
        @(posedge clk);
        @(negedge clk);
        ifb.in_valid = 1'b0;
        lat = 0;
        while (!ifb.out_valid && lat < 50) begin
            ifb.in_bin = 8'($urandom);
            @(negedge clk);
            lat++;
        end
        bcd = ifb.out_bcd;
        ovf = ifb.out_ovf;
    endtask

    task automatic pop_a();
        ifa.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifa.out_ready = 1'b0;
    endtask

    task automatic pop_b();
        ifb.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifb.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_bin = '0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_bin = '0; ifb.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({ifa.out_valid, ifa.out_ovf, ifa.busy, ifa.in_ready, ifa.out_bcd} !== {3'b000, 1'b1, 12'h000}) begin
            fails++;
            $display("FAIL reset_a: v/o/b/r/bcd=%b%b%b%b %h exp 0001 000",
                     ifa.out_valid, ifa.out_ovf, ifa.busy, ifa.in_ready, ifa.out_bcd);
        end
        tests++;
        if ({ifb.out_valid, ifb.out_ovf, ifb.busy, ifb.in_ready, ifb.out_bcd} !== {3'b000, 1'b1, 8'h00}) begin
            fails++;
            $display("FAIL reset_b: v/o/b/r/bcd=%b%b%b%b %h exp 0001 00",
                     ifb.out_valid, ifb.out_ovf, ifb.busy, ifb.in_ready, ifb.out_bcd);
        end
    endtask

    task automatic test_basic();
        logic [7:0]  vals [8] = '{8'd255, 8'd0, 8'd99, 8'd100, 8'd1, 8'd9, 8'd10, 8'd254};
        logic [11:0] bcd;
        logic        ovf;
        int          lat;
        logic [12:0] e;
        for (int i = 0; i < 8; i++) begin
            conv_a(vals[i], bcd, ovf, lat);
            e = ref3(int'(vals[i]));
            tests++;
            if (lat != 8) begin
                fails++;
                $display("FAIL basic_latency(%0d): %0d cycles exp 8", vals[i], lat);
            end
            tests++;
            if ({ovf, bcd} !== e) begin
                fails++;
                $display("FAIL basic_value(%0d): ovf=%b bcd=%h exp ovf=%b bcd=%h", vals[i], ovf, bcd, e[12], e[11:0]);
            end
            pop_a();
        end
        conv_a(8'd255, bcd, ovf, lat);
        tests++;
        if ({ovf, bcd} !== {1'b0, 12'h255}) begin
            fails++;
            $display("FAIL basic_255: ovf=%b bcd=%h exp ovf=0 bcd=255", ovf, bcd);
        end
        pop_a();
    endtask

    task automatic test_backpressure();
        logic [11:0] bcd;
        logic        ovf;
        int          lat;
        conv_a(8'd123, bcd, ovf, lat);
        for (int i = 0; i < 5; i++) begin
            ifa.in_bin = 8'($urandom);
            tests++;
            if ({ifa.out_valid, ifa.in_ready, ifa.out_bcd} !== {1'b1, 1'b0, 12'h123}) begin
                fails++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b bcd=%h exp 1 0 123",
                         i, ifa.out_valid, ifa.in_ready, ifa.out_bcd);
            end
            @(negedge clk);
        end
        ifa.out_ready = 1'b1;
        ifa.in_valid  = 1'b1;
        ifa.in_bin    = 8'd42;
        #1;
        tests++;
        if (ifa.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release_ready: in_ready=%b exp 1", ifa.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b0;
        tests++;
        if ({ifa.busy, ifa.out_valid} !== 2'b10) begin
            fails++;
            $display("FAIL bp_b2b_accept: busy=%b valid=%b exp 1 0", ifa.busy, ifa.out_valid);
        end
        lat = 0;
        while (!ifa.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        tests++;
        if (lat != 8 || ifa.out_bcd !== 12'h042 || ifa.out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL bp_b2b_result: lat=%0d bcd=%h ovf=%b exp 8 042 0", lat, ifa.out_bcd, ifa.out_ovf);
        end
        pop_a();
    endtask

    task automatic test_overflow();
        logic [7:0]  bcd;
        logic        ovf;
        int          lat;
        logic [7:0]  v;
        logic [8:0]  e;
        conv_b(8'd255, bcd, ovf, lat);
        tests++;
        if ({ovf, bcd} !== {1'b1, 8'h55} || lat != 8) begin
            fails++;
            $display("FAIL ovf_255: ovf=%b bcd=%h lat=%0d exp 1 55 8", ovf, bcd, lat);
        end
        pop_b();
        conv_b(8'd37, bcd, ovf, lat);
        tests++;
        if ({ovf, bcd} !== {1'b0, 8'h37}) begin
            fails++;
            $display("FAIL ovf_clear_37: ovf=%b bcd=%h exp 0 37", ovf, bcd);
        end
        pop_b();
        for (int i = 0; i < 16; i++) begin
            v = (i == 0) ? 8'd99 : (i == 1) ? 8'd100 : 8'($urandom);
            conv_b(v, bcd, ovf, lat);
            e = ref2(int'(v));
            tests++;
            if ({ovf, bcd} !== e) begin
                fails++;
                $display("FAIL ovf_rand(%0d): ovf=%b bcd=%h exp ovf=%b bcd=%h", v, ovf, bcd, e[8], e[7:0]);
            end
            pop_b();
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] bcd;
        logic        ovf;
        int          lat;
        ifa.in_valid = 1'b1;
        ifa.in_bin   = 8'd200;
        @(posedge clk);
        @(negedge clk);
        ifa.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if ({ifa.out_valid, ifa.in_ready, ifa.busy, ifa.out_bcd} !== {3'b010, 12'h000}) begin
            fails++;
            $display("FAIL reset_mid: valid=%b ready=%b busy=%b bcd=%h exp 0 1 0 000",
                     ifa.out_valid, ifa.in_ready, ifa.busy, ifa.out_bcd);
        end
        repeat (12) @(negedge clk);
        tests++;
        if (ifa.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_discard: out_valid=%b exp 0", ifa.out_valid);
        end
        conv_a(8'd7, bcd, ovf, lat);
        tests++;
        if ({ovf, bcd} !== {1'b0, 12'h007} || lat != 8) begin
            fails++;
            $display("FAIL reset_mid_after: ovf=%b bcd=%h lat=%0d exp 0 007 8", ovf, bcd, lat);
        end
        pop_a();
    endtask

    task automatic test_sweep();
        logic [7:0]  q [$];
        logic [7:0]  v;
        logic [12:0] e;
        int nxt = 0, got = 0, cyc = 0;
        bit pend = 0;
        while (got < 256 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            ifa.out_ready = ($urandom_range(0, 3) != 0);
            if (!pend && nxt < 256 && $urandom_range(0, 2) != 0) pend = 1;
            ifa.in_valid = pend;
            ifa.in_bin   = pend ? 8'(nxt) : 8'($urandom);
            #1;
            if (ifa.out_valid && ifa.out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL sweep_spurious: result bcd=%h with nothing pending", ifa.out_bcd);
                end else begin
                    v = q.pop_front();
                    e = ref3(int'(v));
                    if ({ifa.out_ovf, ifa.out_bcd} !== e) begin
                        fails++;
                        $display("FAIL sweep(%0d): ovf=%b bcd=%h exp ovf=%b bcd=%h",
                                 v, ifa.out_ovf, ifa.out_bcd, e[12], e[11:0]);
                    end
                end
                got++;
            end
            if (ifa.in_valid && ifa.in_ready) begin
                q.push_back(8'(nxt));
                nxt++;
                pend = 0;
            end
        end
        @(negedge clk);
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b0;
        tests++;
        if (got != 256 || nxt != 256) begin
            fails++;
            $display("FAIL sweep_count: results=%0d accepts=%0d exp 256 256", got, nxt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
